// File: rtl/fft_s2p8.sv
// ============================================================================
// Module      : fft_s2p8
// Description : Serial-to-parallel converter that sits in front of an 8-point
//               FFT core. Complex samples arrive one per cycle and are
//               collected into one of two ping-pong frame banks. Lanes are
//               written in 3-bit bit-reversed order, so the core gets its
//               input already permuted. A bank is presented as one 8-lane
//               frame once it is full, and it is released when the
//               downstream accepts it.
//
// Ports       : clk          - clock; all state changes on the rising edge
//               rst_n        - asynchronous reset, active low
//               din_vld      - the serial sample is valid
//               din_sof      - start of frame, qualified by din_vld
//               din_re/im    - sample components, two's complement
//               din_rdy      - a sample can be accepted this cycle
//               dout_rdy     - the downstream accepts the presented frame
//               vld_out      - a complete frame is presented
//               fft_dout_re  - real lanes; lane k = [k*W +: W]
//               fft_dout_im  - imaginary lanes, same packing
//               frm_err      - sticky: a partial frame was truncated by sof
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_s2p8 #(
    parameter int FFT_DATA_WD = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_vld,
    input  logic                     din_sof,
    input  logic [FFT_DATA_WD-1:0]   din_re,
    input  logic [FFT_DATA_WD-1:0]   din_im,
    output logic                     din_rdy,
    input  logic                     dout_rdy,
    output logic                     vld_out,
    output logic [8*FFT_DATA_WD-1:0] fft_dout_re,
    output logic [8*FFT_DATA_WD-1:0] fft_dout_im,
    output logic                     frm_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]             r_cnt;      // index of the next in-frame sample
    logic                   r_wp;       // bank being filled
    logic                   r_rp;       // bank being presented
    logic [1:0]             r_full;     // per-bank "complete frame" flag
    logic                   r_frm_err;
    logic [FFT_DATA_WD-1:0] r_bank_re [2][8];
    logic [FFT_DATA_WD-1:0] r_bank_im [2][8];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic       w_accept;
    logic       w_consume;
    logic [2:0] w_n;        // sample index used for this sample
    logic [2:0] w_lane;     // bit-reversed destination lane
    logic       w_last;     // this sample completes the frame
    logic       w_trunc;    // sof arrived in the middle of a frame
    logic [1:0] w_full_nxt;

    assign din_rdy   = ~r_full[r_wp];
    assign vld_out   = r_full[r_rp];
    assign w_accept  = din_vld & din_rdy;
    assign w_consume = vld_out & dout_rdy;

    // A sof sample always restarts the frame at index 0. Samples of the
    // truncated frame already sitting in the bank are simply overwritten
    // as the new frame fills all eight lanes before the bank is marked full.
    assign w_n     = din_sof ? 3'd0 : r_cnt;
    assign w_lane  = {w_n[0], w_n[1], w_n[2]};
    assign w_last  = (w_n == 3'd7);
    assign w_trunc = din_sof & (r_cnt != 3'd0);

    // Completion and consumption can land on the same edge; they always
    // touch different banks because a completing bank is never full and a
    // consumed bank always is.
    always_comb begin
        w_full_nxt = r_full;
        if (w_consume) begin
            w_full_nxt[r_rp] = 1'b0;
        end
        if (w_accept && w_last) begin
            w_full_nxt[r_wp] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_full    <= 2'b00;
            r_frm_err <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_consume) begin
                r_rp <= ~r_rp;
            end
            if (w_accept) begin
                r_cnt <= w_last ? 3'd0 : (w_n + 3'd1);
                if (w_last) begin
                    r_wp <= ~r_wp;
                end
                if (w_trunc) begin
                    r_frm_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame banks
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < 8; l++) begin
                    r_bank_re[b][l] <= '0;
                    r_bank_im[b][l] <= '0;
                end
            end
        end else if (w_accept) begin
            r_bank_re[r_wp][w_lane] <= din_re;
            r_bank_im[r_wp][w_lane] <= din_im;
        end
    end

    // ------------------------------------------------------------------
    // Output lanes always reflect the presented bank
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 8; k++) begin : g_lane
            assign fft_dout_re[k*FFT_DATA_WD +: FFT_DATA_WD] = r_bank_re[r_rp][k];
            assign fft_dout_im[k*FFT_DATA_WD +: FFT_DATA_WD] = r_bank_im[r_rp][k];
        end
    endgenerate

    assign frm_err = r_frm_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_s2p8.sv
// ============================================================================
// Module      : tb_fft_s2p8
// Description : Self-checking bench for fft_s2p8. A frame-level model (queue
//               of completed frames plus one partial frame) predicts the
//               handshake, valid, error flag and lane contents every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_s2p8;

    localparam int W = 10;

    logic           clk;
    logic           rst_n;
    logic           din_vld;
    logic           din_sof;
    logic [W-1:0]   din_re;
    logic [W-1:0]   din_im;
    logic           din_rdy;
    logic           dout_rdy;
    logic           vld_out;
    logic [8*W-1:0] fft_dout_re;
    logic [8*W-1:0] fft_dout_im;
    logic           frm_err;

    int n_vec;
    int n_err;

    fft_s2p8 #(.FFT_DATA_WD(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_vld     (din_vld),
        .din_sof     (din_sof),
        .din_re      (din_re),
        .din_im      (din_im),
        .din_rdy     (din_rdy),
        .dout_rdy    (dout_rdy),
        .vld_out     (vld_out),
        .fft_dout_re (fft_dout_re),
        .fft_dout_im (fft_dout_im),
        .frm_err     (frm_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: completed frames waiting for the consumer (at most
    // two can be held), plus the samples of the frame being assembled.
    // ------------------------------------------------------------------
    logic [8*W-1:0] m_q_re[$];
    logic [8*W-1:0] m_q_im[$];
    logic [W-1:0]   m_part_re[8];
    logic [W-1:0]   m_part_im[8];
    int             m_part_n;
    logic           m_err;

    function automatic int bitrev3(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    task automatic model_reset();
        m_q_re.delete();
        m_q_im.delete();
        m_part_n = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        bit con;
        logic [8*W-1:0] fr;
        logic [8*W-1:0] fi;
        acc = din_vld && (m_q_re.size() < 2);
        con = (m_q_re.size() > 0) && dout_rdy;
        if (con) begin
            void'(m_q_re.pop_front());
            void'(m_q_im.pop_front());
        end
        if (acc) begin
            if (din_sof) begin
                if (m_part_n != 0) m_err = 1'b1;
                m_part_n = 0;
            end
            m_part_re[m_part_n] = din_re;
            m_part_im[m_part_n] = din_im;
            m_part_n++;
            if (m_part_n == 8) begin
                for (int k = 0; k < 8; k++) begin
                    fr[k*W +: W] = m_part_re[bitrev3(k)];
                    fi[k*W +: W] = m_part_im[bitrev3(k)];
                end
                m_q_re.push_back(fr);
                m_q_im.push_back(fi);
                m_part_n = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Comparisons
    // ------------------------------------------------------------------
    task automatic check1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic checkw(input string tag, input logic [8*W-1:0] obs,
                          input logic [8*W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check1("din_rdy", din_rdy, m_q_re.size() < 2);
        check1("vld_out", vld_out, m_q_re.size() > 0);
        check1("frm_err", frm_err, m_err);
        if (m_q_re.size() > 0) begin
            checkw("dout_re", fft_dout_re, m_q_re[0]);
            checkw("dout_im", fft_dout_im, m_q_im[0]);
        end
    endtask

    // One clock cycle: drive, check the pre-edge outputs, clock, update model.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] re,
                         input logic [W-1:0] im, input logic rdy);
        din_vld  = v;
        din_sof  = s;
        din_re   = re;
        din_im   = im;
        dout_rdy = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rnd(input logic v, input logic s, input logic rdy);
        cycle(v, s, W'($urandom), W'($urandom), rdy);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int             exp_l[8];
        logic [8*W-1:0] lanes;
        logic [8*W-1:0] held;

        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        din_vld  = 1'b0;
        din_sof  = 1'b0;
        din_re   = '0;
        din_im   = '0;
        dout_rdy = 1'b0;
        model_reset();

        // Reset values
        @(posedge clk);
        #1;
        check_outputs();
        checkw("rst_dout_re", fft_dout_re, '0);
        checkw("rst_dout_im", fft_dout_im, '0);
        check1("rst_din_rdy", din_rdy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single ramp frame: re 1..8, im -1..-8
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i == 0, W'(i + 1), W'(-(i + 1)), 1'b1);
        end
        exp_l = '{1, 5, 3, 7, 2, 6, 4, 8};
        for (int k = 0; k < 8; k++) lanes[k*W +: W] = W'(exp_l[k]);
        check1("ramp_vld", vld_out, 1'b1);
        checkw("ramp_lanes_re", fft_dout_re, lanes);
        check1("ramp_err", frm_err, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check1("ramp_pulse_end", vld_out, 1'b0);

        // Four back-to-back frames
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) rnd(1'b1, i == 0, 1'b1);
        end
        rnd(1'b0, 1'b0, 1'b1);
        rnd(1'b0, 1'b0, 1'b1);

        // Backpressure: 20 offered samples, only 16 fit
        for (int i = 0; i < 20; i++) rnd(1'b1, (i % 8) == 0, 1'b0);
        check1("bp_rdy_low", din_rdy, 1'b0);
        held = fft_dout_re;
        rnd(1'b0, 1'b0, 1'b0);
        rnd(1'b0, 1'b0, 1'b0);
        checkw("bp_hold", fft_dout_re, held);
        rnd(1'b0, 1'b0, 1'b1);
        check1("bp_rdy_back", din_rdy, 1'b1);
        rnd(1'b0, 1'b0, 1'b0);
        rnd(1'b0, 1'b0, 1'b1);
        rnd(1'b0, 1'b0, 1'b1);

        // Truncated frame: 3 samples, then a new sof frame
        for (int i = 0; i < 3; i++) rnd(1'b1, i == 0, 1'b1);
        for (int i = 0; i < 8; i++) rnd(1'b1, i == 0, 1'b1);
        check1("trunc_err", frm_err, 1'b1);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b0, 1'b1);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 8; i++) rnd(1'b1, i == 0, 1'b0);
        for (int i = 0; i < 5; i++) rnd(1'b1, i == 0, 1'b0);
        din_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        checkw("arst_dout_re", fft_dout_re, '0);
        checkw("arst_dout_im", fft_dout_im, '0);
        check1("arst_err", frm_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rnd(1'b1, 1'b0, 1'b1);
        rnd(1'b0, 1'b0, 1'b1);
        rnd(1'b0, 1'b0, 1'b1);

        // Completion and consumption on the same edge
        for (int i = 0; i < 8; i++) rnd(1'b1, i == 0, 1'b0);
        for (int i = 0; i < 7; i++) rnd(1'b1, i == 0, 1'b0);
        rnd(1'b1, 1'b0, 1'b1);
        check1("same_edge_vld", vld_out, 1'b1);
        rnd(1'b0, 1'b0, 1'b0);
        rnd(1'b0, 1'b0, 1'b1);
        rnd(1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
